xor_unit_arbiter: RTL and testbench
===================================

Name: xor_unit_arbiter

Overview:
Sequencing controller that shares one Xor_32Bit instance between two requesters. It arbitrates round-robin, latches the winner's operands, and drives them through the shared XOR unit. It registers the result and returns it with a one-cycle done pulse. It sits between the ALU-level XOR datapath and two client blocks, for example a checksum engine and the register-file write path.

Parameters:
WIDTH, 32, operand/result width; the Xor_32Bit instance is used only when WIDTH == 32, otherwise an equivalent bitwise XOR is generated
CNT_W, 16, width of the per-requester statistics counters (optional feature only)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; held high until gnt0 is seen
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
req1  input  1  requester 1 request
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
done0  output  1  one-cycle pulse: result valid for requester 0
done1  output  1  one-cycle pulse: result valid for requester 1
result  output  WIDTH  registered a XOR b of the last completed operation
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- On reset:
  - state = IDLE; all outputs 0; result = 0.
  - Operand registers cleared.
  - last_winner = 1, so requester 0 wins the first tie.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - At a clock edge with req0 or req1 high, select the winner and capture its a/b into op_a/op_b.
  - Set owner = winner, assert gnt<owner> for the next cycle only, go to EXEC.
  - With no request, stay in IDLE.
- Winner selection:
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_winner wins.
  - last_winner updates at the grant edge.
- EXEC:
  - op_a/op_b drive the shared XOR unit (combinational).
  - At the edge: result <= op_a ^ op_b; go to DONE.
- DONE:
  - done<owner> high for this one cycle; result valid.
  - Go to IDLE at the next edge. No request is accepted while in DONE.
- Latency: request sampled at edge k → gnt high in cycle k+1 → done high and result updated in cycle k+2. Earliest next grant is edge k+3, so throughput is 1 operation per 3 cycles.
- result holds its value until the next completion. done0 and done1 are never high together. gnt0 and gnt1 are never high together.
- A requester may drop req or change operands in the cycle after it sees gnt. Operands are already latched.
- A req still high in DONE or IDLE after completion counts as a new request.
- Requests arriving while busy are not lost and not queued; they are served when req is still high in IDLE.
- Reset asserted in EXEC or DONE: the operation is aborted and no done pulse is produced. All state returns to reset values at that edge.
- Arithmetic: pure bitwise XOR, no carry and no flags. Width is exactly WIDTH.

Optional Feature:
Macro XOR_ARB_STATS_EN.
- Defined:
  - Adds outputs cnt0 and cnt1 [CNT_W-1:0].
  - Each counter increments by 1 at the edge where its done pulse is high.
  - Counters saturate at all-ones and do not wrap.
  - Reset clears both counters.
- Not defined: the ports and counters are absent. Core behaviour is identical in both cases.

Test Plan:
- Reset, then req0=1, a0=32'hFFFFFFFF, b0=32'h00000000 → gnt0 in cycle 1, done0 and result=32'hFFFFFFFF in cycle 2, busy=0 in cycle 3.
- req0 and req1 both high from reset: a0=32'h12311111, b0=32'h00100000; a1=32'h10000100, b1=32'h11000010. Required sequence:
  - requester 0 served first, result=32'h12211111;
  - then requester 1, result=32'h01000110;
  - grants alternate 0,1,0,1 while both requests stay high.
- req1 only, a1=32'h11111000, b1=32'h00001111 → gnt1 then done1, result=32'h11110111; gnt0/done0 stay 0.
- req0 rises in the cycle after gnt1 → not granted until the cycle after done1. Check the 3-cycle spacing and no lost request.
- reset asserted during EXEC → no done pulse; result=0; next tie is won by requester 0.
- With XOR_ARB_STATS_EN and CNT_W=2: complete 5 operations for requester 0 → cnt0 = 3 (saturated), cnt1 = 0.

Source files
------------

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one Xor_32Bit unit between two requesters.
// Optional per-requester completion counters: define XOR_ARB_STATS_EN.
module Xor_32Bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

module xor_unit_arbiter #(
  parameter int unsigned WIDTH = 32
`ifdef XOR_ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef XOR_ARB_STATS_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  logic             r_owner;
  logic             r_last_winner;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             w_winner;
  logic [WIDTH-1:0] w_xor;

  // On a tie the requester that did not win last time gets the grant.
  assign w_winner = (req0 && req1) ? ~r_last_winner : req1;

  generate
    if (WIDTH == 32) begin : g_xor32
      Xor_32Bit u_xor (
        .a (r_op_a),
        .b (r_op_b),
        .y (w_xor)
      );
    end else begin : g_xorn
      assign w_xor = r_op_a ^ r_op_b;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_winner <= 1'b1;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_result      <= '0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_owner       <= w_winner;
            r_last_winner <= w_winner;
            r_op_a        <= w_winner ? a1 : a0;
            r_op_b        <= w_winner ? b1 : b0;
            r_gnt0        <= ~w_winner;
            r_gnt1        <= w_winner;
            r_state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_xor;
          r_done0  <= ~r_owner;
          r_done1  <= r_owner;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef XOR_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (r_done0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
      if (r_done1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter; stats checks run when XOR_ARB_STATS_EN is defined.
module tb_xor_unit_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        req1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic        busy;
  int          n_tests;
  int          n_fail;
`ifdef XOR_ARB_STATS_EN
  logic [1:0]  cnt0;
  logic [1:0]  cnt1;
`endif

`ifdef XOR_ARB_STATS_EN
  xor_unit_arbiter #(.WIDTH(32), .CNT_W(2)) dut (
`else
  xor_unit_arbiter #(.WIDTH(32)) dut (
`endif
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy)
`ifdef XOR_ARB_STATS_EN
    , .cnt0 (cnt0)
    , .cnt1 (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    chk("rst_gnt0",   {31'd0, gnt0},  32'd0);
    chk("rst_gnt1",   {31'd0, gnt1},  32'd0);
    chk("rst_done0",  {31'd0, done0}, 32'd0);
    chk("rst_done1",  {31'd0, done1}, 32'd0);
    chk("rst_result", result,         32'd0);
    chk("rst_busy",   {31'd0, busy},  32'd0);

    // Single request from requester 0
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'hFFFFFFFF; b0 = 32'h00000000;
    tick();
    chk("t1_gnt0", {31'd0, gnt0}, 32'd1);
    chk("t1_gnt1", {31'd0, gnt1}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("t1_done0",  {31'd0, done0}, 32'd1);
    chk("t1_gnt0_off", {31'd0, gnt0}, 32'd0);
    chk("t1_result", result, 32'hFFFFFFFF);
    tick();
    chk("t1_idle",  {31'd0, busy},  32'd0);
    chk("t1_done_off", {31'd0, done0}, 32'd0);
    chk("t1_hold",  result, 32'hFFFFFFFF);

    // Both requesting from reset: alternation 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'h12311111; b0 = 32'h00100000;
    req1 = 1'b1; a1 = 32'h10000100; b1 = 32'h11000010;
    for (int op = 0; op < 4; op++) begin
      tick();
      chk("t2_gnt0", {31'd0, gnt0}, (op % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_gnt1", {31'd0, gnt1}, (op % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("t2_done0", {31'd0, done0}, (op % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_done1", {31'd0, done1}, (op % 2 == 1) ? 32'd1 : 32'd0);
      chk("t2_result", result, (op % 2 == 0) ? 32'h12211111 : 32'h01000110);
      tick();
      chk("t2_idle", {31'd0, busy}, 32'd0);
    end

    // Requester 1 alone
    req0 = 1'b0;
    req1 = 1'b1; a1 = 32'h11111000; b1 = 32'h00001111;
    tick();
    chk("t3_gnt1", {31'd0, gnt1}, 32'd1);
    chk("t3_gnt0", {31'd0, gnt0}, 32'd0);
    req1 = 1'b0;
    tick();
    chk("t3_done1",  {31'd0, done1}, 32'd1);
    chk("t3_done0",  {31'd0, done0}, 32'd0);
    chk("t3_result", result, 32'h11110111);

    // req0 rises during DONE: not accepted until the following IDLE edge
    req0 = 1'b1; a0 = 32'hA5A5A5A5; b0 = 32'hFFFF0000;
    tick();
    chk("t4_no_gnt", {31'd0, gnt0}, 32'd0);
    chk("t4_idle",   {31'd0, busy}, 32'd0);
    tick();
    chk("t4_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("t4_done0",  {31'd0, done0}, 32'd1);
    chk("t4_result", result, 32'h5A5AA5A5);
    tick();
    chk("t4_idle2", {31'd0, busy}, 32'd0);

    // Reset during EXEC aborts; last_winner returns to 1
    req0 = 1'b1; a0 = 32'h0F0F0F0F; b0 = 32'h00000000;
    tick();
    chk("t5_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5_done0",  {31'd0, done0}, 32'd0);
    chk("t5_done1",  {31'd0, done1}, 32'd0);
    chk("t5_result", result, 32'd0);
    chk("t5_busy",   {31'd0, busy}, 32'd0);
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'h12311111; b0 = 32'h00100000;
    req1 = 1'b1; a1 = 32'h10000100; b1 = 32'h11000010;
    tick();
    chk("t5_tie_gnt0", {31'd0, gnt0}, 32'd1);
    chk("t5_tie_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    chk("t5_done0r",  {31'd0, done0}, 32'd1);
    chk("t5_result2", result, 32'h12211111);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

`ifdef XOR_ARB_STATS_EN
    // Five requester-0 completions saturate a 2-bit counter at 3
    reset = 1'b1;
    tick();
    chk("s_rst_cnt0", {30'd0, cnt0}, 32'd0);
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'h00000001; b0 = 32'h00000002;
    for (int i = 0; i < 6; i++) tick();
    chk("s_cnt0_2", {30'd0, cnt0}, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    req0 = 1'b0;
    tick();
    chk("s_cnt0_sat", {30'd0, cnt0}, 32'd3);
    chk("s_cnt1",     {30'd0, cnt1}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(done0 && done1)) else begin
        n_fail++;
        $error("FAIL done_excl: observed both done high expected at most one");
      end
      assert (!(gnt0 && gnt1)) else begin
        n_fail++;
        $error("FAIL gnt_excl: observed both gnt high expected at most one");
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
